// File: rtl/retire_trace_serializer.sv
// Retire trace serializer: captures up to IssueWidth retired records per cycle
// into a FIFO and streams them out one per cycle in program order.
// Overflow is all-or-nothing per cycle. Drops and retire-slot gaps are counted or flagged.
module retire_trace_serializer #(
  parameter int IssueWidth = 2,
  parameter int Depth      = 16,
  parameter int Xlen       = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [IssueWidth-1:0]      update_i,
  input  logic [IssueWidth*Xlen-1:0] pc_i,
  input  logic [IssueWidth*Xlen-1:0] instr_i,
  input  logic [IssueWidth*5-1:0]    reg_addr_i,
  input  logic [IssueWidth*Xlen-1:0] reg_data_i,
  input  logic [IssueWidth*Xlen-1:0] mem_addr_i,
  input  logic [IssueWidth*Xlen-1:0] mem_data_i,
  input  logic [IssueWidth-1:0]      mem_wrt_i,
  output logic                       rec_valid_o,
  input  logic                       rec_ready_i,
  output logic [31:0]                rec_seq_o,
  output logic [Xlen-1:0]            rec_pc_o,
  output logic [Xlen-1:0]            rec_instr_o,
  output logic [4:0]                 rec_reg_addr_o,
  output logic [Xlen-1:0]            rec_reg_data_o,
  output logic [Xlen-1:0]            rec_mem_addr_o,
  output logic [Xlen-1:0]            rec_mem_data_o,
  output logic                       rec_mem_wrt_o,
  output logic [31:0]                retired_cnt_o,
  output logic [31:0]                drop_cnt_o,
  output logic                       overflow_o,
  output logic                       proto_err_o
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  // Record storage, one array per field. Entries are not reset. The read side
  // masks them with rec_valid_o, so stale contents never reach the outputs.
  logic [31:0]     seq_mem      [Depth];
  logic [Xlen-1:0] pc_mem       [Depth];
  logic [Xlen-1:0] instr_mem    [Depth];
  logic [4:0]      reg_addr_mem [Depth];
  logic [Xlen-1:0] reg_data_mem [Depth];
  logic [Xlen-1:0] mem_addr_mem [Depth];
  logic [Xlen-1:0] mem_data_mem [Depth];
  logic            mem_wrt_mem  [Depth];

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] free_slots;
  logic [PW-1:0] n_valid;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] slot_idx [IssueWidth];
  logic [31:0]   slot_seq [IssueWidth];
  logic          push_ok;
  logic          overflow_evt;
  logic          pop;
  logic          gap;

  // The accepted-record count also supplies the next sequence number.
  // Dropped records do not advance it, so sequence numbers stay dense.
  logic [31:0] seq_cnt;
  assign seq_cnt = retired_cnt_o;

  // Pack the valid slots densely, in ascending slot order.
  // The offset of each slot is the number of valid slots below it.
  always_comb begin
    n_valid = '0;
    for (int k = 0; k < IssueWidth; k++) begin
      slot_idx[k] = wr_ptr[AW-1:0] + n_valid[AW-1:0];
      slot_seq[k] = seq_cnt + 32'(n_valid);
      n_valid     = n_valid + PW'(update_i[k]);
    end
  end

  // Free space is taken before this cycle's pop, so a pop in the same cycle
  // never makes room for a push in that cycle.
  assign occupancy    = wr_ptr - rd_ptr;
  assign free_slots   = PW'(Depth) - occupancy;
  assign push_ok      = (update_i != '0) && (n_valid <= free_slots);
  assign overflow_evt = (n_valid > free_slots);

  // Output stream handshake: rec_valid_o is high whenever the FIFO holds a record.
  // The head fields hold steady while rec_valid_o && !rec_ready_i.
  // A record is consumed at a rising edge where rec_valid_o && rec_ready_i.
  assign rec_valid_o = (occupancy != '0);
  assign pop         = rec_valid_o && rec_ready_i;
  assign rd_idx      = rd_ptr[AW-1:0];

  // A gap means a younger slot retired while an older slot did not.
  always_comb begin
    gap = 1'b0;
    for (int k = 1; k < IssueWidth; k++) begin
      gap = gap | (update_i[k] & ~update_i[k-1]);
    end
  end

  // Write the valid slots into consecutive entries when the whole group fits.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      for (int k = 0; k < IssueWidth; k++) begin
        if (update_i[k]) begin
          seq_mem[slot_idx[k]]      <= slot_seq[k];
          pc_mem[slot_idx[k]]       <= pc_i[k*Xlen +: Xlen];
          instr_mem[slot_idx[k]]    <= instr_i[k*Xlen +: Xlen];
          reg_addr_mem[slot_idx[k]] <= reg_addr_i[k*5 +: 5];
          reg_data_mem[slot_idx[k]] <= reg_data_i[k*Xlen +: Xlen];
          mem_addr_mem[slot_idx[k]] <= mem_addr_i[k*Xlen +: Xlen];
          mem_data_mem[slot_idx[k]] <= mem_data_i[k*Xlen +: Xlen];
          mem_wrt_mem[slot_idx[k]]  <= mem_wrt_i[k];
        end
      end
    end
  end

  // Pointers, counters and sticky flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      retired_cnt_o <= '0;
      drop_cnt_o    <= '0;
      overflow_o    <= 1'b0;
      proto_err_o   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr        <= wr_ptr + n_valid;
        retired_cnt_o <= retired_cnt_o + 32'(n_valid);
      end
      if (overflow_evt) begin
        drop_cnt_o <= drop_cnt_o + 32'(n_valid);
        overflow_o <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (gap) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  // Drive the head entry as first-word-fall-through. Outputs are zero when empty.
  always_comb begin
    rec_seq_o      = '0;
    rec_pc_o       = '0;
    rec_instr_o    = '0;
    rec_reg_addr_o = '0;
    rec_reg_data_o = '0;
    rec_mem_addr_o = '0;
    rec_mem_data_o = '0;
    rec_mem_wrt_o  = 1'b0;
    if (rec_valid_o) begin
      rec_seq_o      = seq_mem[rd_idx];
      rec_pc_o       = pc_mem[rd_idx];
      rec_instr_o    = instr_mem[rd_idx];
      rec_reg_addr_o = reg_addr_mem[rd_idx];
      rec_reg_data_o = reg_data_mem[rd_idx];
      rec_mem_addr_o = mem_addr_mem[rd_idx];
      rec_mem_data_o = mem_data_mem[rd_idx];
      rec_mem_wrt_o  = mem_wrt_mem[rd_idx];
    end
  end

endmodule
